// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths, default depth and flush FSM encoding for the hazard controller
package hazard_pkg;
    localparam int REG_W = 5;
    localparam int DEPTH_DEF = 3;
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination register shift register with parallel RAW compare
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [REG_W-1:0] a0,
    input  logic [REG_W-1:0] a1,
    input  logic [REG_W-1:0] a2_hazard,
    output logic             raw
);
    logic [DEPTH-1:0][REG_W-1:0] sb;
    // youngest destination enters sb[0]; the oldest retires out of sb[DEPTH-1]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else if (!hold) begin
            sb[0] <= a2_hazard;
            for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
        end
    end
    // x0 never hazards; a1 is always checked, even for immediate forms
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            raw = raw | (a0 != '0 && a0 == sb[i]) | (a1 != '0 && a1 == sb[i]);
    end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: RAW stall, jump flush FSM and memory-wait freeze for the pipeline
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] a0,
    input  logic [REG_W-1:0] a1,
    input  logic [REG_W-1:0] a2_hazard,
    input  logic             jmp_taken,
    input  logic             mem_wait,
    output logic             stall,
    output logic             stall_front,
    output logic             squash,
    output logic             flushing
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic raw;
    logic flush_now;
    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk(clk),
        .rst(rst),
        .hold(stall),
        .a0(a0),
        .a1(a1),
        .a2_hazard(a2_hazard),
        .raw(raw)
    );
    // flush FSM; memory-wait cycles neither advance nor consume flush cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt <= '0;
        end else if (!mem_wait) begin
            if (jmp_taken) begin
                state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                cnt <= RELOAD;
            end else if (state == FLUSH) begin
                state <= (cnt == CW'(1)) ? RUN : FLUSH;
                cnt <= cnt - 1'b1;
            end
        end
    end
    // priority mux: freeze > flush/jump > RAW bubble; squash never looks at a2_hazard
    always_comb begin
        flush_now = (state == FLUSH) | jmp_taken;
        stall = rst & mem_wait;
        stall_front = rst & (mem_wait | (~flush_now & raw));
        squash = rst & ~mem_wait & (flush_now | raw);
        flushing = rst & (state == FLUSH);
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with a queued scoreboard checked by a separate monitor
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] a0 = '0, a1 = '0, a2_hazard = '0;
    logic jmp_taken = 1'b0, mem_wait = 1'b0;
    logic stall, stall_front, squash, flushing;
    typedef struct {
        logic [3:0] e;
        string n;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;

    hazard_controller #(.DEPTH(3), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .a0(a0),
        .a1(a1),
        .a2_hazard(a2_hazard),
        .jmp_taken(jmp_taken),
        .mem_wait(mem_wait),
        .stall(stall),
        .stall_front(stall_front),
        .squash(squash),
        .flushing(flushing)
    );

    always #5 clk = ~clk;

    // expected vector is {stall, stall_front, squash, flushing}
    task automatic cyc(input logic r, input logic [4:0] x0, input logic [4:0] x1, input logic [4:0] x2,
                       input logic j, input logic m, input logic [3:0] e, input string n);
        exp_t it;
        @(posedge clk);
        #1;
        rst = r; a0 = x0; a1 = x1; a2_hazard = x2; jmp_taken = j; mem_wait = m;
        it.e = e; it.n = n;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            it = q.pop_front();
            tests++;
            if ({stall, stall_front, squash, flushing} !== it.e) begin
                fails++;
                $display("FAIL %s: got %b expected %b", it.n, {stall, stall_front, squash, flushing}, it.e);
            end
        end
    end

    initial begin
        exp_t it;
        // reset state, including a reset with mem_wait pending
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, "reset");
        cyc(0, 0, 0, 0, 0, 1, 4'b0000, "reset_memwait");
        cyc(1, 5, 5, 0, 0, 0, 4'b0000, "empty_sb");
        // back-to-back dependency: three bubbles, clear on the fourth
        cyc(1, 0, 0, 5, 0, 0, 4'b0000, "producer");
        cyc(1, 5, 0, 0, 0, 0, 4'b0110, "raw1");
        cyc(1, 5, 0, 0, 0, 0, 4'b0110, "raw2");
        cyc(1, 5, 0, 0, 0, 0, 4'b0110, "raw3");
        cyc(1, 5, 0, 0, 0, 0, 4'b0000, "raw_clear");
        // a1 dependency one slot behind
        cyc(1, 0, 0, 7, 0, 0, 4'b0000, "producer7");
        cyc(1, 0, 3, 0, 0, 0, 4'b0000, "a1_nohaz");
        cyc(1, 0, 7, 0, 0, 0, 4'b0110, "a1_raw1");
        cyc(1, 0, 7, 0, 0, 0, 4'b0110, "a1_raw2");
        cyc(1, 0, 7, 0, 0, 0, 4'b0000, "a1_clear");
        // x0 never hazards
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, "x0_write");
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, "x0_read");
        // jump: two squash cycles, flushing on the second
        cyc(1, 0, 0, 0, 1, 0, 4'b0010, "jmp");
        cyc(1, 0, 0, 0, 0, 0, 4'b0011, "flush");
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, "flush_done");
        // jump beats RAW: no stall_front
        cyc(1, 0, 0, 4, 0, 0, 4'b0000, "producer4");
        cyc(1, 4, 0, 0, 1, 0, 4'b0010, "jmp_wins");
        cyc(1, 0, 0, 0, 0, 0, 4'b0011, "jmp_wins_flush");
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, "jmp_wins_done");
        // memory wait inside flush freezes the count
        cyc(1, 0, 0, 0, 1, 0, 4'b0010, "jmp2");
        cyc(1, 0, 0, 0, 0, 1, 4'b1101, "mw_flush1");
        cyc(1, 0, 0, 0, 0, 1, 4'b1101, "mw_flush2");
        cyc(1, 0, 0, 0, 0, 1, 4'b1101, "mw_flush3");
        cyc(1, 0, 0, 0, 0, 0, 4'b0011, "flush_resume");
        cyc(1, 0, 0, 0, 0, 0, 4'b0000, "resume_done");
        // memory wait freezes the scoreboard
        cyc(1, 0, 0, 6, 0, 0, 4'b0000, "producer6");
        cyc(1, 6, 0, 0, 0, 1, 4'b1100, "mw_raw1");
        cyc(1, 6, 0, 0, 0, 1, 4'b1100, "mw_raw2");
        cyc(1, 6, 0, 0, 0, 0, 4'b0110, "held_raw1");
        cyc(1, 6, 0, 0, 0, 0, 4'b0110, "held_raw2");
        cyc(1, 6, 0, 0, 0, 0, 4'b0110, "held_raw3");
        cyc(1, 6, 0, 0, 0, 0, 4'b0000, "held_clear");
        // async reset mid-flush, then the scoreboard must be empty
        cyc(1, 0, 0, 9, 0, 0, 4'b0000, "producer9");
        cyc(1, 0, 0, 0, 1, 0, 4'b0010, "jmp3");
        @(posedge clk);
        #2;
        rst = 0; a0 = 0; a1 = 0; a2_hazard = 0; jmp_taken = 0; mem_wait = 0;
        it.e = 4'b0000; it.n = "async_reset";
        q.push_back(it);
        cyc(1, 9, 0, 0, 0, 0, 4'b0000, "sb_cleared");
        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
